// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The arbiter's optional stall statistics are enabled with DMEM_ARBITER_STATS_EN.
package dmem_arb_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    GRANT_CORE = 2'd0,
    GRANT_AUX  = 2'd1,
    AUX_RESP   = 2'd2
  } arbState_e;

  // True when the address lies inside a memory of 2**addrLen words.
  function automatic logic inRange(input logic [ADDR_W-1:0] addr, input int unsigned addrLen);
    if (addrLen >= ADDR_W) begin
      return 1'b1;
    end
    return (addr >> addrLen) == {ADDR_W{1'b0}};
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core, the auxiliary requester, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              i_core_req;
  logic              i_core_wr_en;
  logic [ADDR_W-1:0] i_core_addr;
  logic [WORD_W-1:0] i_core_wr_data;
  logic [WORD_W-1:0] o_core_rd_data;
  logic              o_core_stall;

  logic              i_aux_valid;
  logic              i_aux_wr_en;
  logic [ADDR_W-1:0] i_aux_addr;
  logic [WORD_W-1:0] i_aux_wr_data;
  logic              o_aux_ready;
  logic              o_aux_rd_valid;
  logic [WORD_W-1:0] o_aux_rd_data;

  logic              o_mem_wr_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wr_data;
  logic [WORD_W-1:0] i_mem_rd_data;

  modport slave (
    input  i_core_req, i_core_wr_en, i_core_addr, i_core_wr_data,
    output o_core_rd_data, o_core_stall,
    input  i_aux_valid, i_aux_wr_en, i_aux_addr, i_aux_wr_data,
    output o_aux_ready, o_aux_rd_valid, o_aux_rd_data,
    output o_mem_wr_en, o_mem_addr, o_mem_wr_data,
    input  i_mem_rd_data
  );

  modport master (
    output i_core_req, i_core_wr_en, i_core_addr, i_core_wr_data,
    input  o_core_rd_data, o_core_stall,
    output i_aux_valid, i_aux_wr_en, i_aux_addr, i_aux_wr_data,
    input  o_aux_ready, o_aux_rd_valid, o_aux_rd_data,
    input  o_mem_wr_en, o_mem_addr, o_mem_wr_data,
    output i_mem_rd_data
  );

endinterface

// File: rtl/dmem_arb_ager.sv
// Aux starvation guard: counts cycles the aux requester has waited behind the core
// and raises o_force on the cycle that brings the wait to p_MAX_WAIT.
module dmem_arb_ager #(
  parameter int p_MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_force
);

  logic [3:0] waitCnt_q;
  logic [3:0] waitCnt_d;

  // The current waiting cycle counts toward the limit, so the comparison uses the incremented value.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (i_clear) begin
      waitCnt_d = 4'd0;
    end else if (i_inc) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
    o_force = i_inc && (({1'b0, waitCnt_q} + 5'd1) == 5'(p_MAX_WAIT));
  end

  // Wait counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      waitCnt_q <= 4'd0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: the core has priority, the aux port gets
// single-cycle grants when the core is idle or after waiting p_AUX_MAX_WAIT cycles.
// Define DMEM_ARBITER_STATS_EN to build the saturating core-stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int p_ADDR_LEN     = 10,
  parameter int p_AUX_MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dmem_arbiter_if.slave     bus,
  output logic [WORD_W-1:0] o_conflict_count
);

  arbState_e state_q;
  logic      coreRange_q;
  logic      auxRange_q;
  logic      coreInRange;
  logic      auxInRange;
  logic      agerInc;
  logic      forceGrant;

  assign coreInRange = inRange(bus.i_core_addr, p_ADDR_LEN);
  assign auxInRange  = inRange(bus.i_aux_addr, p_ADDR_LEN);
  assign agerInc     = (state_q == GRANT_CORE) && bus.i_aux_valid && bus.i_core_req;

  dmem_arb_ager #(
    .p_MAX_WAIT(p_AUX_MAX_WAIT)
  ) u_ager (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (agerInc),
    .i_clear (state_q == GRANT_AUX),
    .o_force (forceGrant)
  );

  // Ownership FSM; aux grants always return through GRANT_CORE so they never run back to back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= GRANT_CORE;
    end else begin
      case (state_q)
        GRANT_CORE: begin
          if (bus.i_aux_valid && (!bus.i_core_req || forceGrant)) begin
            state_q <= GRANT_AUX;
          end
        end
        GRANT_AUX: state_q <= bus.i_aux_wr_en ? GRANT_CORE : AUX_RESP;
        default:   state_q <= GRANT_CORE;
      endcase
    end
  end

  // Remember whether last cycle's addresses were real so returning data can be masked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coreRange_q <= 1'b0;
      auxRange_q  <= 1'b0;
    end else begin
      coreRange_q <= coreInRange;
      auxRange_q  <= auxInRange;
    end
  end

  // Memory steering and handshake outputs; reset silences every strobe immediately.
  always_comb begin
    bus.o_mem_addr     = bus.i_core_addr;
    bus.o_mem_wr_data  = bus.i_core_wr_data;
    bus.o_mem_wr_en    = bus.i_core_req && bus.i_core_wr_en && coreInRange;
    bus.o_core_stall   = 1'b0;
    bus.o_aux_ready    = 1'b0;
    bus.o_aux_rd_valid = 1'b0;
    case (state_q)
      GRANT_AUX: begin
        bus.o_mem_addr    = bus.i_aux_addr;
        bus.o_mem_wr_data = bus.i_aux_wr_data;
        bus.o_mem_wr_en   = bus.i_aux_valid && bus.i_aux_wr_en && auxInRange;
        bus.o_aux_ready   = 1'b1;
        bus.o_core_stall  = bus.i_core_req;
      end
      AUX_RESP: bus.o_aux_rd_valid = 1'b1;
      default: ;
    endcase
    if (i_rst) begin
      bus.o_mem_wr_en    = 1'b0;
      bus.o_core_stall   = 1'b0;
      bus.o_aux_ready    = 1'b0;
      bus.o_aux_rd_valid = 1'b0;
    end
  end

  assign bus.o_core_rd_data = coreRange_q ? bus.i_mem_rd_data : {WORD_W{1'b0}};
  assign bus.o_aux_rd_data  = auxRange_q ? bus.i_mem_rd_data : {WORD_W{1'b0}};

`ifdef DMEM_ARBITER_STATS_EN
  logic [WORD_W-1:0] conflictCnt_q;

  // Saturating tally of cycles the core spent stalled behind an aux grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conflictCnt_q <= {WORD_W{1'b0}};
    end else if (bus.o_core_stall && (conflictCnt_q != {WORD_W{1'b1}})) begin
      conflictCnt_q <= conflictCnt_q + 1'b1;
    end
  end

  assign o_conflict_count = conflictCnt_q;
`else
  assign o_conflict_count = {WORD_W{1'b0}};
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter p_ADDR_LEN, default 10, data-memory address bits (in-range iff addr < 2**p_ADDR_LEN).
REQ-002 SHALL have parameter p_AUX_MAX_WAIT, default 4, max consecutive aux wait cycles before forced aux grant (1..15).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have core ports i_core_req 1, i_core_wr_en 1, i_core_addr 16, i_core_wr_data 16 (inputs); o_core_rd_data 16, o_core_stall 1 (outputs).
REQ-006 SHALL have aux ports i_aux_valid 1, i_aux_wr_en 1, i_aux_addr 16, i_aux_wr_data 16 (inputs); o_aux_ready 1, o_aux_rd_valid 1, o_aux_rd_data 16 (outputs).
REQ-007 SHALL have memory ports o_mem_wr_en 1, o_mem_addr 16, o_mem_wr_data 16 (outputs); i_mem_rd_data 16 (input, valid one cycle after address).
REQ-008 SHALL have port o_conflict_count  output  16  saturating count of core-stall cycles.

Function
REQ-009 SHALL implement FSM states GRANT_CORE, GRANT_AUX, AUX_RESP.
REQ-010 GRANT_CORE: core owns memory; mem outputs = core inputs combinationally; o_core_stall=0; o_aux_ready=0.
REQ-011 Aux wait counter SHALL increment each GRANT_CORE cycle with i_aux_valid=1 and i_core_req=1; SHALL clear when aux granted.
REQ-012 GRANT_CORE -> GRANT_AUX when i_aux_valid=1 and (i_core_req=0 or wait counter == p_AUX_MAX_WAIT).
REQ-013 GRANT_AUX (one cycle): mem outputs = aux inputs; o_aux_ready=1 (handshake completes this cycle); o_core_stall = i_core_req.
REQ-014 GRANT_AUX -> AUX_RESP if aux read, else -> GRANT_CORE.
REQ-015 AUX_RESP (one cycle): o_aux_rd_valid=1, o_aux_rd_data = gated i_mem_rd_data; memory returned to core (core not stalled); next state GRANT_CORE.
REQ-016 Core read data SHALL be i_mem_rd_data gated by registered in-range flag of previous-cycle core address; out of range -> 16'h0000.
REQ-017 Out-of-range write (either requester) SHALL force o_mem_wr_en=0; aux handshake still completes.
REQ-018 Aux inputs SHALL be held stable by requester while i_aux_valid=1 and o_aux_ready=0.
REQ-019 Aux may not be granted in back-to-back cycles; at least one GRANT_CORE cycle between aux grants.
REQ-020 No memory write SHALL occur when neither requester is granted-and-writing; idle mem outputs: wr_en=0, addr/wr_data = core inputs.

Reset
REQ-021 i_rst=1 at any edge SHALL force state GRANT_CORE, wait counter 0, range flag 0, o_conflict_count 0.
REQ-022 During reset: o_core_stall=0, o_aux_ready=0, o_aux_rd_valid=0, o_mem_wr_en=0; in-flight aux read discarded, no o_aux_rd_valid afterwards.

Configuration
REQ-023 Macro DMEM_ARBITER_STATS_EN defined: o_conflict_count increments on each cycle o_core_stall=1, saturates at 16'hFFFF.
REQ-024 Macro undefined: counter logic omitted, o_conflict_count tied to 16'h0000; all other behaviour identical.

Structure
REQ-025 Package dmem_arb_pkg SHALL hold the FSM state enum and the 16-bit word/address width constants.
REQ-026 Sub-module dmem_arb_ager SHALL implement the aux wait counter and forced-grant comparison.

Verification
REQ-027 Core-only: core writes 16'hBEEF to 33, then reads 33 -> o_core_rd_data=16'hBEEF next cycle, o_core_stall never 1.
REQ-028 Idle core: aux write 16'h1234 to 5 with i_core_req=0 -> o_aux_ready=1 in 1 cycle; later core read 5 returns 16'h1234.
REQ-029 Starvation: core requests every cycle, aux read valid, p_AUX_MAX_WAIT=4 -> aux granted in 5th cycle, o_core_stall=1 exactly that cycle, o_aux_rd_valid next cycle.
REQ-030 Out-of-range: core write addr 16'h0400 with p_ADDR_LEN=10 -> o_mem_wr_en=0; core read 16'h0400 -> 16'h0000.
REQ-031 Reset mid-op: i_rst=1 in AUX_RESP cycle -> no o_aux_rd_valid, state GRANT_CORE, o_conflict_count=0.
REQ-032 Stats: 3 forced aux grants under continuous core traffic -> o_conflict_count=3 with DMEM_ARBITER_STATS_EN, 0 without.
